// File: rtl/md_issue_ctrl.sv
// D-to-E issue register for MDU ops with a shadow busy countdown and MDU-conflict stall.
// Optional macro MD_STALL_ALL_EN: stall every valid D instruction while the MDU is busy.
module md_issue_ctrl #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_valid,
    input  logic [3:0]  d_md_sel,
    input  logic [31:0] d_rs,
    input  logic [31:0] d_rt,
    input  logic        ext_stall,
    input  logic        e_flush,
    output logic [3:0]  e_md_sel,
    output logic [31:0] e_d1,
    output logic [31:0] e_d2,
    output logic        d_stall,
    output logic        md_busy,
    output logic [3:0]  md_cnt
);

    localparam logic [3:0] MUL_LD = 4'(MUL_LAT);
    localparam logic [3:0] DIV_LD = 4'(DIV_LAT);

    function automatic logic f_is_start(input logic [3:0] sel);
        f_is_start = (sel >= 4'd1) && (sel <= 4'd4);
    endfunction

    function automatic logic f_is_mul(input logic [3:0] sel);
        f_is_mul = (sel == 4'd1) || (sel == 4'd2);
    endfunction

    function automatic logic f_is_mdu(input logic [3:0] sel);
        f_is_mdu = (sel >= 4'd1) && (sel <= 4'd8);
    endfunction

    logic [3:0]  r_e_sel;
    logic [31:0] r_e_d1;
    logic [31:0] r_e_d2;
    logic [3:0]  r_cnt;
    logic        w_mdu_active;
    logic        w_stall;
    logic [3:0]  w_d_sel;

    // Conflict stall and the op code that would be loaded into E.
    always_comb begin
        w_mdu_active = f_is_start(r_e_sel) || (r_cnt != 4'd0);
`ifdef MD_STALL_ALL_EN
        w_stall = d_valid && w_mdu_active;
`else
        w_stall = d_valid && f_is_mdu(d_md_sel) && w_mdu_active;
`endif
        if (d_valid && (d_md_sel <= 4'd8)) begin
            w_d_sel = d_md_sel;
        end else begin
            w_d_sel = 4'd0;
        end
    end

    // E-stage register: flush and stalls both inject a zeroed bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e_sel <= 4'd0;
            r_e_d1  <= 32'd0;
            r_e_d2  <= 32'd0;
        end else if (e_flush || w_stall || ext_stall) begin
            r_e_sel <= 4'd0;
            r_e_d1  <= 32'd0;
            r_e_d2  <= 32'd0;
        end else begin
            r_e_sel <= w_d_sel;
            r_e_d1  <= d_rs;
            r_e_d2  <= d_rt;
        end
    end

    // Busy countdown; an op sitting in E has already reached the MDU, so flush does not cancel the load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 4'd0;
        end else if (f_is_mul(r_e_sel)) begin
            r_cnt <= MUL_LD;
        end else if (f_is_start(r_e_sel)) begin
            r_cnt <= DIV_LD;
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end else begin
            r_cnt <= 4'd0;
        end
    end

    assign e_md_sel = r_e_sel;
    assign e_d1     = r_e_d1;
    assign e_d2     = r_e_d2;
    assign md_cnt   = r_cnt;
    assign md_busy  = (r_cnt != 4'd0);
    assign d_stall  = w_stall;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed self-checking bench for md_issue_ctrl (MUL_LAT=5, DIV_LAT=10).
module tb_md_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        d_valid;
    logic [3:0]  d_md_sel;
    logic [31:0] d_rs;
    logic [31:0] d_rt;
    logic        ext_stall;
    logic        e_flush;
    logic [3:0]  e_md_sel;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    logic        d_stall;
    logic        md_busy;
    logic [3:0]  md_cnt;

    int n_cmp;
    int n_err;
    int k;
    int nst;

    md_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_md_sel(d_md_sel),
        .d_rs(d_rs), .d_rt(d_rt), .ext_stall(ext_stall), .e_flush(e_flush),
        .e_md_sel(e_md_sel), .e_d1(e_d1), .e_d2(e_d2), .d_stall(d_stall),
        .md_busy(md_busy), .md_cnt(md_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] sel, input logic [31:0] rs, input logic [31:0] rt);
        d_valid  = v;
        d_md_sel = sel;
        d_rs     = rs;
        d_rt     = rt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        ext_stall = 1'b0;
        e_flush = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        tick;
        tick;
        chk("rst_sel",   32'(e_md_sel), 32'd0);
        chk("rst_d1",    e_d1,          32'd0);
        chk("rst_d2",    e_d2,          32'd0);
        chk("rst_cnt",   32'(md_cnt),   32'd0);
        chk("rst_busy",  32'(md_busy),  32'd0);
        chk("rst_stall", 32'(d_stall),  32'd0);
        reset = 1'b0;

        // mult then mflo
        drive(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3);
        tick;
        chk("mul_sel", 32'(e_md_sel), 32'd1);
        chk("mul_d1",  e_d1,          32'hFFFF_FFFE);
        chk("mul_d2",  e_d2,          32'd3);
        chk("mul_cnt0", 32'(md_cnt),  32'd0);
        drive(1'b1, 4'd6, 32'd0, 32'd0);
        #1;
        chk("mflo_stall0", 32'(d_stall), 32'd1);
        nst = 0;
        k = 0;
        while (e_md_sel !== 4'd6 && k < 20) begin
            if (d_stall) nst++;
            tick;
            k++;
            if (k == 1) chk("mul_one_cycle", 32'(e_md_sel), 32'd0);
            if (k <= 6) chk("mul_cnt", 32'(md_cnt), 32'(6 - k));
        end
        chk("mflo_arrival", 32'(k), 32'd7);
        chk("mflo_stalls", 32'(nst), 32'd6);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        tick;

        // async reset mid-countdown
        drive(1'b1, 4'd3, 32'd5, 32'd6);
        tick;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) tick;
        chk("div_cnt7", 32'(md_cnt), 32'd7);
        drive(1'b1, 4'd5, 32'd0, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_cnt",   32'(md_cnt),   32'd0);
        chk("arst_busy",  32'(md_busy),  32'd0);
        chk("arst_stall", 32'(d_stall),  32'd0);
        chk("arst_sel",   32'(e_md_sel), 32'd0);
        reset = 1'b0;
        tick;
        chk("arst_mfhi", 32'(e_md_sel), 32'd5);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        tick;

        // flush with mthi in D, no stall
        drive(1'b1, 4'd7, 32'h0000_1234, 32'h0000_5678);
        e_flush = 1'b1;
        #1;
        chk("fl_stall", 32'(d_stall), 32'd0);
        tick;
        chk("fl_sel", 32'(e_md_sel), 32'd0);
        chk("fl_d1",  e_d1,          32'd0);
        chk("fl_cnt", 32'(md_cnt),   32'd0);
        e_flush = 1'b0;
        tick;
        chk("mthi_sel", 32'(e_md_sel), 32'd7);
        chk("mthi_d1",  e_d1,          32'h0000_1234);

        // flush together with stall while mult sits in E
        drive(1'b1, 4'd1, 32'd2, 32'd2);
        tick;
        drive(1'b1, 4'd8, 32'd9, 32'd0);
        e_flush = 1'b1;
        #1;
        chk("flst_stall", 32'(d_stall), 32'd1);
        tick;
        chk("flst_sel", 32'(e_md_sel), 32'd0);
        chk("flst_cnt", 32'(md_cnt),   32'd5);
        e_flush = 1'b0;
        k = 0;
        while (e_md_sel !== 4'd8 && k < 20) begin
            tick;
            k++;
        end
        chk("mtlo_issue", 32'(k), 32'd6);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        tick;

        // ext_stall holds divu out of E
        drive(1'b1, 4'd4, 32'd40, 32'd8);
        ext_stall = 1'b1;
        #1;
        chk("ext_dstall", 32'(d_stall), 32'd0);
        tick;
        chk("ext_sel", 32'(e_md_sel), 32'd0);
        chk("ext_cnt", 32'(md_cnt),   32'd0);
        tick;
        chk("ext_cnt2", 32'(md_cnt), 32'd0);
        ext_stall = 1'b0;
        tick;
        chk("divu_sel", 32'(e_md_sel), 32'd4);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        tick;
        chk("divu_cnt",  32'(md_cnt),  32'd10);
        chk("divu_busy", 32'(md_busy), 32'd1);
`ifndef MD_STALL_ALL_EN
        drive(1'b1, 4'd12, 32'd1, 32'd1);
        #1;
        chk("bad_code_stall", 32'(d_stall), 32'd0);
        drive(1'b0, 4'd1, 32'd1, 32'd1);
        #1;
        chk("invalid_stall", 32'(d_stall), 32'd0);
        tick;
        chk("invalid_sel", 32'(e_md_sel), 32'd0);
        drive(1'b1, 4'd12, 32'd1, 32'd1);
        tick;
        chk("bad_code_sel", 32'(e_md_sel), 32'd0);
        chk("divu_cnt8", 32'(md_cnt), 32'd8);
`endif
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        k = 0;
        while (md_busy && k < 30) begin
            tick;
            k++;
        end
        chk("drain", 32'(md_busy), 32'd0);

`ifndef MD_STALL_ALL_EN
        // div, addu, addu, mfhi
        drive(1'b1, 4'd3, 32'd100, 32'd7);
        tick;
        chk("div_sel", 32'(e_md_sel), 32'd3);
        drive(1'b1, 4'd0, 32'd1, 32'd2);
        #1;
        chk("addu1_stall", 32'(d_stall), 32'd0);
        tick;
        chk("addu1_busy", 32'(md_busy), 32'd1);
        chk("addu1_cnt",  32'(md_cnt),  32'd10);
        #1;
        chk("addu2_stall", 32'(d_stall), 32'd0);
        tick;
        chk("addu2_cnt", 32'(md_cnt), 32'd9);
        drive(1'b1, 4'd5, 32'd0, 32'd0);
        nst = 0;
        k = 0;
        while (e_md_sel !== 4'd5 && k < 30) begin
            #1;
            if (d_stall) nst++;
            tick;
            k++;
        end
        chk("mfhi_arrival", 32'(k), 32'd10);
        chk("mfhi_stalls", 32'(nst), 32'd9);
`else
        // stall-all: ordinary op behind multu
        drive(1'b1, 4'd2, 32'd3, 32'd4);
        tick;
        drive(1'b1, 4'd0, 32'd0, 32'd0);
        #1;
        nst = 0;
        k = 0;
        while (d_stall && k < 20) begin
            nst++;
            tick;
            k++;
        end
        chk("stall_all_cycles", 32'(nst), 32'd6);
`endif
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
